// File: rtl/pwr_seq_pkg.sv
// Shared types and step tables for the board power sequencer.
// Step order, request mapping and PGOOD qualification live here so the top stays table-driven.
package pwr_seq_pkg;

    localparam int unsigned N_STEPS = 7;

    typedef logic [2:0] step_idx_t;

    localparam step_idx_t STEP_ADC_A   = 3'd0;
    localparam step_idx_t STEP_ADC_D   = 3'd1;
    localparam step_idx_t STEP_TDC_3V3 = 3'd2;
    localparam step_idx_t STEP_TDC_2V5 = 3'd3;
    localparam step_idx_t STEP_SHAPER  = 3'd4;
    localparam step_idx_t STEP_STRIP   = 3'd5;
    localparam step_idx_t STEP_BIAS    = 3'd6;

    typedef enum logic [1:0] {
        StIdle,
        StRampUp,
        StRampDown,
        StFault
    } state_e;

    typedef enum logic {
        FaultTimeout = 1'b0,
        FaultPgLost  = 1'b1
    } fault_kind_e;

    // Request bit that enables each step, indexed by step.
    localparam logic [2:0] STEP_REQ_BIT [N_STEPS] = '{
        3'd0, 3'd0, 3'd3, 3'd3, 3'd2, 3'd4, 3'd5
    };

    // Steps whose completion is qualified by PGOOD; the rest use a fixed settle wait.
    localparam logic [N_STEPS-1:0] STEP_HAS_PG = 7'b001_0111;

    // HV bias is only allowed together with the strip supplies.
    function automatic logic [N_STEPS-1:0] desired_steps(input logic [5:0] req);
        logic [N_STEPS-1:0] d;
        d = '0;
        for (int i = 0; i < int'(N_STEPS); i++) begin
            d[i] = req[STEP_REQ_BIT[i]];
        end
        d[STEP_BIAS] = d[STEP_BIAS] & req[STEP_REQ_BIT[STEP_STRIP]];
        return d;
    endfunction

endpackage

// File: rtl/pwr_pg_sync.sv
// Two-flop synchronizer bank for asynchronous PGOOD inputs.
// Synchronous active-high reset clears both stages.
module pwr_pg_sync #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pwr_seq_ctrl.sv
// Ordered, PGOOD-qualified rail sequencer: one step moves at a time, faults kill every rail.
// Define PWR_SEQ_PG_MONITOR_EN to also fault when a completed step loses PGOOD at runtime.
module pwr_seq_ctrl
    import pwr_seq_pkg::*;
#(
    parameter int unsigned PG_TIMEOUT    = 40000,
    parameter int unsigned SETTLE_CYCLES = 4000,
    parameter int unsigned OFF_DELAY     = 4000
) (
    input  logic       dtc_clk,
    input  logic       rst,
    input  logic [5:0] reg_pwr_en,
    input  logic       fault_clr,
    input  logic       pgood_1v8a_adc,
    input  logic       pgood_1v8d_adc,
    input  logic       pgood_1v2d_adc,
    input  logic       pgood_3v3_tdc,
    input  logic       pgood_3v3_shaper,
    output logic       on_1v8a_adc,
    output logic       on_1v8d_adc,
    output logic       on_1v2d_adc,
    output logic       on_3v3_tdc,
    output logic       on_2v5_tdc,
    output logic       on_3v3_shaper,
    output logic       on_5v0_sum,
    output logic       on_12v5,
    output logic       on_n5v0,
    output logic       on_5v0_bias,
    output logic       busy,
    output logic       pwr_ready,
    output logic       fault,
    output logic [2:0] fault_step,
    output logic       fault_kind
);

    localparam int unsigned MAX_A   = (PG_TIMEOUT > SETTLE_CYCLES) ? PG_TIMEOUT : SETTLE_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_A > OFF_DELAY) ? MAX_A : OFF_DELAY;
    localparam int unsigned TW      = $clog2(MAX_CYC + 1);

    localparam logic [TW-1:0] PG_LAST     = TW'(PG_TIMEOUT - 1);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] OFF_LAST    = TW'(OFF_DELAY - 1);

    state_e              state_q, state_d;
    logic [N_STEPS-1:0]  on_q, on_d;
    logic [TW-1:0]       timer_q, timer_d, timer_inc;
    step_idx_t           step_q, step_d;
    logic                fault_q, fault_d;
    step_idx_t           fault_step_q, fault_step_d;
    fault_kind_e         fault_kind_q, fault_kind_d;
    logic                pwr_ready_q, pwr_ready_d;

    logic [4:0]          pg_raw, pg_s;
    logic [N_STEPS-1:0]  step_pg;
    logic [N_STEPS-1:0]  desired;
    logic [N_STEPS-1:0]  down_mask, up_mask;
    step_idx_t           dn_idx, up_idx;
`ifdef PWR_SEQ_PG_MONITOR_EN
    logic [N_STEPS-1:0]  lost;
    step_idx_t           lost_idx;
`endif

    assign pg_raw = {pgood_3v3_shaper, pgood_3v3_tdc, pgood_1v2d_adc, pgood_1v8d_adc,
                     pgood_1v8a_adc};

    pwr_pg_sync #(
        .Width (5)
    ) u_pg_sync (
        .clk_i (dtc_clk),
        .rst_i (rst),
        .d_i   (pg_raw),
        .q_o   (pg_s)
    );

    // Per-step PGOOD view; settle steps read as never-good and are not consulted.
    always_comb begin
        step_pg               = '0;
        step_pg[STEP_ADC_A]   = pg_s[0] & pg_s[1];
        step_pg[STEP_ADC_D]   = pg_s[2];
        step_pg[STEP_TDC_3V3] = pg_s[3];
        step_pg[STEP_SHAPER]  = pg_s[4];
    end

    assign desired = desired_steps(reg_pwr_en);

    always_ff @(posedge dtc_clk) begin
        if (rst) begin
            state_q      <= StIdle;
            on_q         <= '0;
            timer_q      <= '0;
            step_q       <= '0;
            fault_q      <= 1'b0;
            fault_step_q <= '0;
            fault_kind_q <= FaultTimeout;
            pwr_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            on_q         <= on_d;
            timer_q      <= timer_d;
            step_q       <= step_d;
            fault_q      <= fault_d;
            fault_step_q <= fault_step_d;
            fault_kind_q <= fault_kind_d;
            pwr_ready_q  <= pwr_ready_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        on_d         = on_q;
        timer_d      = timer_q;
        step_d       = step_q;
        fault_d      = fault_q;
        fault_step_d = fault_step_q;
        fault_kind_d = fault_kind_q;

        timer_inc = (timer_q == {TW{1'b1}}) ? timer_q : timer_q + TW'(1);

        down_mask = on_q & ~desired;
        up_mask   = desired & ~on_q;
        dn_idx    = '0;
        up_idx    = '0;
        for (int i = 0; i < int'(N_STEPS); i++) begin
            if (down_mask[i]) dn_idx = step_idx_t'(i);
        end
        for (int i = int'(N_STEPS) - 1; i >= 0; i--) begin
            if (up_mask[i]) up_idx = step_idx_t'(i);
        end

        unique case (state_q)
            StIdle: begin
                if (down_mask != '0) begin
                    on_d[dn_idx] = 1'b0;
                    step_d       = dn_idx;
                    timer_d      = '0;
                    state_d      = StRampDown;
                end else if (up_mask != '0) begin
                    on_d[up_idx] = 1'b1;
                    step_d       = up_idx;
                    timer_d      = '0;
                    state_d      = StRampUp;
                end
            end
            StRampUp: begin
                timer_d = timer_inc;
                if (STEP_HAS_PG[step_q]) begin
                    // Completion wins over a timeout landing on the same cycle.
                    if (step_pg[step_q]) begin
                        state_d = StIdle;
                    end else if (timer_q == PG_LAST) begin
                        state_d      = StFault;
                        on_d         = '0;
                        fault_d      = 1'b1;
                        fault_step_d = step_q;
                        fault_kind_d = FaultTimeout;
                    end
                end else if (timer_q == SETTLE_LAST) begin
                    state_d = StIdle;
                end
            end
            StRampDown: begin
                timer_d = timer_inc;
                if (timer_q == OFF_LAST) state_d = StIdle;
            end
            StFault: begin
                if (fault_clr) begin
                    state_d      = StIdle;
                    fault_d      = 1'b0;
                    fault_step_d = '0;
                    fault_kind_d = FaultTimeout;
                end
            end
            default: state_d = StIdle;
        endcase

`ifdef PWR_SEQ_PG_MONITOR_EN
        // The step still ramping up has not proven PGOOD yet, so it is not watched.
        lost = on_q & STEP_HAS_PG & ~step_pg;
        if (state_q == StRampUp) lost[step_q] = 1'b0;
        lost_idx = '0;
        for (int i = int'(N_STEPS) - 1; i >= 0; i--) begin
            if (lost[i]) lost_idx = step_idx_t'(i);
        end
        if ((state_q != StFault) && (lost != '0)) begin
            state_d      = StFault;
            on_d         = '0;
            timer_d      = '0;
            fault_d      = 1'b1;
            fault_step_d = lost_idx;
            fault_kind_d = FaultPgLost;
        end
`endif

        pwr_ready_d = (state_d == StIdle) && (on_d == desired);
    end

    always_comb begin
        on_1v8a_adc   = on_q[STEP_ADC_A];
        on_1v8d_adc   = on_q[STEP_ADC_A];
        on_1v2d_adc   = on_q[STEP_ADC_D];
        on_3v3_tdc    = on_q[STEP_TDC_3V3];
        on_2v5_tdc    = on_q[STEP_TDC_2V5];
        on_3v3_shaper = on_q[STEP_SHAPER];
        on_5v0_sum    = on_q[STEP_SHAPER];
        on_12v5       = on_q[STEP_STRIP];
        on_n5v0       = on_q[STEP_STRIP];
        on_5v0_bias   = on_q[STEP_BIAS];
        busy          = (state_q == StRampUp) || (state_q == StRampDown);
        pwr_ready     = pwr_ready_q;
        fault         = fault_q;
        fault_step    = fault_step_q;
        fault_kind    = fault_kind_q;
    end

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Randomized bench for pwr_seq_ctrl: a PGOOD responder plus a step-plan model that predicts
// every rail change, busy window and pwr_ready from the sequencing rules.
module tb_pwr_seq_ctrl;

    localparam int unsigned PG_TIMEOUT    = 16;
    localparam int unsigned SETTLE_CYCLES = 4;
    localparam int unsigned OFF_DELAY     = 4;
    localparam logic [6:0]  HAS_PG        = 7'b001_0111;

    logic       dtc_clk;
    logic       rst;
    logic [5:0] reg_pwr_en;
    logic       fault_clr;
    logic       pgood_1v8a_adc, pgood_1v8d_adc, pgood_1v2d_adc, pgood_3v3_tdc, pgood_3v3_shaper;
    logic       on_1v8a_adc, on_1v8d_adc, on_1v2d_adc, on_3v3_tdc, on_2v5_tdc;
    logic       on_3v3_shaper, on_5v0_sum, on_12v5, on_n5v0, on_5v0_bias;
    logic       busy, pwr_ready, fault, fault_kind;
    logic [2:0] fault_step;

    int         n_checks;
    int         n_bad;
    logic [6:0] exp_on;
    int         pg_dly [7];
    int         pg_cnt [7];
    logic [4:0] pg_kill;
    logic [6:0] resp_s, resp_lvl;
    logic [9:0] rails;
    logic [6:0] step_on;

    pwr_seq_ctrl #(
        .PG_TIMEOUT    (PG_TIMEOUT),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .OFF_DELAY     (OFF_DELAY)
    ) dut (
        .dtc_clk          (dtc_clk),
        .rst              (rst),
        .reg_pwr_en       (reg_pwr_en),
        .fault_clr        (fault_clr),
        .pgood_1v8a_adc   (pgood_1v8a_adc),
        .pgood_1v8d_adc   (pgood_1v8d_adc),
        .pgood_1v2d_adc   (pgood_1v2d_adc),
        .pgood_3v3_tdc    (pgood_3v3_tdc),
        .pgood_3v3_shaper (pgood_3v3_shaper),
        .on_1v8a_adc      (on_1v8a_adc),
        .on_1v8d_adc      (on_1v8d_adc),
        .on_1v2d_adc      (on_1v2d_adc),
        .on_3v3_tdc       (on_3v3_tdc),
        .on_2v5_tdc       (on_2v5_tdc),
        .on_3v3_shaper    (on_3v3_shaper),
        .on_5v0_sum       (on_5v0_sum),
        .on_12v5          (on_12v5),
        .on_n5v0          (on_n5v0),
        .on_5v0_bias      (on_5v0_bias),
        .busy             (busy),
        .pwr_ready        (pwr_ready),
        .fault            (fault),
        .fault_step       (fault_step),
        .fault_kind       (fault_kind)
    );

    assign rails   = {on_5v0_bias, on_n5v0, on_12v5, on_5v0_sum, on_3v3_shaper, on_2v5_tdc,
                      on_3v3_tdc, on_1v2d_adc, on_1v8d_adc, on_1v8a_adc};
    assign step_on = {on_5v0_bias, on_12v5, on_3v3_shaper, on_2v5_tdc, on_3v3_tdc,
                      on_1v2d_adc, on_1v8a_adc};

    initial begin
        dtc_clk = 1'b0;
        forever #5 dtc_clk = ~dtc_clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h required=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] model_desired(input logic [5:0] r);
        return {r[5] & r[4], r[4], r[2], r[3], r[3], r[0], r[0]};
    endfunction

    function automatic logic [9:0] rails_of(input logic [6:0] s);
        return {s[6], s[5], s[5], s[4], s[4], s[3], s[2], s[1], s[0], s[0]};
    endfunction

    // Board model: each PGOOD rail reports good pg_dly cycles after its enable, unless killed.
    initial begin
        pgood_1v8a_adc   = 1'b0;
        pgood_1v8d_adc   = 1'b0;
        pgood_1v2d_adc   = 1'b0;
        pgood_3v3_tdc    = 1'b0;
        pgood_3v3_shaper = 1'b0;
        for (int k = 0; k < 7; k++) pg_cnt[k] = 0;
        forever begin
            @(posedge dtc_clk);
            #1;
            resp_s = step_on;
            for (int k = 0; k < 7; k++) begin
                if (resp_s[k]) begin
                    if (pg_cnt[k] < 15) pg_cnt[k]++;
                end else begin
                    pg_cnt[k] = 0;
                end
                resp_lvl[k] = resp_s[k] && (pg_cnt[k] >= pg_dly[k]);
            end
            pgood_1v8a_adc   = resp_lvl[0] & ~pg_kill[0];
            pgood_1v8d_adc   = resp_lvl[0] & ~pg_kill[1];
            pgood_1v2d_adc   = resp_lvl[1] & ~pg_kill[2];
            pgood_3v3_tdc    = resp_lvl[2] & ~pg_kill[3];
            pgood_3v3_shaper = resp_lvl[4] & ~pg_kill[4];
        end
    end

    // Called at a falling edge with the sequencer settled: plans every step move toward
    // the new request and checks rails, busy, pwr_ready and fault on each following cycle.
    task automatic run_to(input logic [5:0] req);
        logic [6:0] des, cur, ev;
        logic       eb;
        int         chg_cyc [$];
        logic [6:0] chg_vec [$];
        int         chg_gap [$];
        int         t, idx, gap, ready_at;
        des = model_desired(req);
        cur = exp_on;
        t   = 1;
        while (cur != des) begin
            if ((cur & ~des) != 7'b0) begin
                idx = 0;
                for (int i = 0; i < 7; i++) if (cur[i] && !des[i]) idx = i;
                cur[idx] = 1'b0;
                gap = OFF_DELAY + 1;
            end else begin
                idx = 0;
                for (int i = 6; i >= 0; i--) if (des[i] && !cur[i]) idx = i;
                cur[idx] = 1'b1;
                gap = HAS_PG[idx] ? pg_dly[idx] + 3 : SETTLE_CYCLES + 1;
            end
            chg_cyc.push_back(t);
            chg_vec.push_back(cur);
            chg_gap.push_back(gap);
            t += gap;
        end
        ready_at = (chg_cyc.size() == 0) ? 1 : t - 1;
        reg_pwr_en = req;
        for (int c = 1; c <= ready_at + 2; c++) begin
            @(negedge dtc_clk);
            ev = exp_on;
            eb = 1'b0;
            foreach (chg_cyc[k]) begin
                if (c >= chg_cyc[k]) begin
                    ev = chg_vec[k];
                    if (c <= chg_cyc[k] + chg_gap[k] - 2) eb = 1'b1;
                end
            end
            check_eq($sformatf("rails req=%b c=%0d", req, c), 32'(rails), 32'(rails_of(ev)));
            check_eq($sformatf("busy req=%b c=%0d", req, c), 32'(busy), 32'(eb));
            check_eq($sformatf("ready req=%b c=%0d", req, c), 32'(pwr_ready),
                     32'(c >= ready_at));
            check_eq($sformatf("nofault req=%b c=%0d", req, c), 32'(fault), 32'd0);
        end
        exp_on = des;
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int got = 0;
        for (int i = 0; i < budget && got == 0; i++) begin
            @(negedge dtc_clk);
            got = int'(pwr_ready);
        end
        check_eq(tag, 32'(got), 32'd1);
    endtask

    initial begin
        int r1;
        int got;
        n_checks   = 0;
        n_bad      = 0;
        rst        = 1'b1;
        reg_pwr_en = 6'b0;
        fault_clr  = 1'b0;
        pg_kill    = 5'b0;
        exp_on     = 7'b0;
        for (int k = 0; k < 7; k++) pg_dly[k] = 3;

        repeat (3) @(negedge dtc_clk);
        check_eq("rst_rails", 32'(rails), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ready", 32'(pwr_ready), 32'd0);
        check_eq("rst_fault", 32'(fault), 32'd0);
        check_eq("rst_fault_step", 32'(fault_step), 32'd0);
        check_eq("rst_fault_kind", 32'(fault_kind), 32'd0);
        rst = 1'b0;

        run_to(6'b111101);
        run_to(6'b000000);
        run_to(6'b100000);

        fault_clr = 1'b1;
        @(negedge dtc_clk);
        fault_clr = 1'b0;
        check_eq("clr_idle_fault", 32'(fault), 32'd0);
        check_eq("clr_idle_rails", 32'(rails), 32'(rails_of(exp_on)));
        check_eq("clr_idle_ready", 32'(pwr_ready), 32'd1);

        repeat (10) begin
            for (int k = 0; k < 7; k++) pg_dly[k] = int'($urandom_range(1, 4));
            run_to(6'($urandom_range(0, 63)));
        end

        // Ramp timeout on the 1V2D step.
        run_to(6'b000000);
        pg_dly[0]  = int'($urandom_range(1, 4));
        pg_kill    = 5'b00100;
        reg_pwr_en = 6'b000001;
        r1 = 1 + pg_dly[0] + 3;
        for (int c = 1; c <= r1 + 17; c++) begin
            @(negedge dtc_clk);
            if (c == r1) check_eq("to_1v2d_rise", 32'(rails), 32'(rails_of(7'b0000011)));
            if (c == r1 + 15) begin
                check_eq("to_prefault", 32'(fault), 32'd0);
                check_eq("to_prefault_rails", 32'(rails), 32'(rails_of(7'b0000011)));
            end
            if (c == r1 + 16) begin
                check_eq("to_fault", 32'(fault), 32'd1);
                check_eq("to_rails_off", 32'(rails), 32'd0);
                check_eq("to_fault_step", 32'(fault_step), 32'd1);
                check_eq("to_fault_kind", 32'(fault_kind), 32'd0);
            end
            if (c == r1 + 17) begin
                check_eq("to_rails_hold", 32'(rails), 32'd0);
                check_eq("to_busy", 32'(busy), 32'd0);
                check_eq("to_ready", 32'(pwr_ready), 32'd0);
            end
        end
        fault_clr = 1'b1;
        pg_kill   = 5'b0;
        @(negedge dtc_clk);
        fault_clr = 1'b0;
        check_eq("to_clr_fault", 32'(fault), 32'd0);
        check_eq("to_clr_step", 32'(fault_step), 32'd0);
        check_eq("to_clr_rails", 32'(rails), 32'd0);
        @(negedge dtc_clk);
        check_eq("to_restart_adc", 32'(rails), 32'(rails_of(7'b0000001)));
        wait_ready("to_recover_ready", 200);
        check_eq("to_recover_rails", 32'(rails), 32'(rails_of(7'b0000011)));
        exp_on = 7'b0000011;

        // Runtime PGOOD loss on the shaper rail.
        for (int k = 0; k < 7; k++) pg_dly[k] = 2;
        run_to(6'b111101);
        pg_kill = 5'b10000;
`ifdef PWR_SEQ_PG_MONITOR_EN
        for (int c = 1; c <= 4; c++) begin
            @(negedge dtc_clk);
            if (c == 3) begin
                check_eq("rt_prefault", 32'(fault), 32'd0);
                check_eq("rt_prefault_rails", 32'(rails), 32'(rails_of(7'b1111111)));
            end
            if (c == 4) begin
                check_eq("rt_fault", 32'(fault), 32'd1);
                check_eq("rt_rails_off", 32'(rails), 32'd0);
                check_eq("rt_fault_step", 32'(fault_step), 32'd4);
                check_eq("rt_fault_kind", 32'(fault_kind), 32'd1);
            end
        end
        pg_kill   = 5'b0;
        fault_clr = 1'b1;
        @(negedge dtc_clk);
        fault_clr = 1'b0;
        check_eq("rt_clr_fault", 32'(fault), 32'd0);
        wait_ready("rt_recover_ready", 300);
        check_eq("rt_recover_rails", 32'(rails), 32'(rails_of(7'b1111111)));
`else
        for (int c = 1; c <= 12; c++) begin
            @(negedge dtc_clk);
            check_eq($sformatf("rt_nofault c=%0d", c), 32'(fault), 32'd0);
            check_eq($sformatf("rt_rails c=%0d", c), 32'(rails), 32'(rails_of(exp_on)));
        end
        pg_kill = 5'b0;
        repeat (4) @(negedge dtc_clk);
`endif
        exp_on = 7'b1111111;

        // Reset in the middle of the 3V3 TDC ramp.
        run_to(6'b000000);
        reg_pwr_en = 6'b111101;
        got = 0;
        for (int i = 0; i < 100 && got == 0; i++) begin
            @(negedge dtc_clk);
            got = int'(on_3v3_tdc);
        end
        check_eq("mr_reach_step2", 32'(got), 32'd1);
        check_eq("mr_busy_step2", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge dtc_clk);
        check_eq("mr_rails", 32'(rails), 32'd0);
        check_eq("mr_busy", 32'(busy), 32'd0);
        check_eq("mr_ready", 32'(pwr_ready), 32'd0);
        check_eq("mr_fault", 32'(fault), 32'd0);
        rst    = 1'b0;
        exp_on = 7'b0;
        run_to(6'b111101);
        run_to(6'b000000);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/pwr_seq_ctrl.md
# pwr_seq_ctrl

Board power sequencer between the DTC command register bank and the FEC rail-enable pins. It converts the static `reg_pwr_en` request word into ordered, PGOOD-qualified rail switching: power-up runs in ascending step order, power-down runs in descending order, and only one step moves at a time. A rail that fails to come up, or one that drops while in use, shuts every rail off and latches a fault. The block runs in the `dtc_clk` domain.

## Interface
- `PG_TIMEOUT`, default 40000: cycles allowed for a PGOOD-qualified step to report good (1 ms at 40 MHz).
- `SETTLE_CYCLES`, default 4000: fixed on-wait for steps with no PGOOD.
- `OFF_DELAY`, default 4000: wait after each rail-off before the next action.

Ports:
- `dtc_clk`  in  1  sole clock.
- `rst`  in  1  reset; **synchronous, active-high** (fixed).
- `reg_pwr_en`  in  6  requests: [0] ADC, [2] shaper, [3] TDC, [4] strip, [5] HV bias; [1] ignored.
- `fault_clr`  in  1  single-cycle pulse; leaves FAULT.
- `pgood_1v8a_adc`, `pgood_1v8d_adc`, `pgood_1v2d_adc`, `pgood_3v3_tdc`, `pgood_3v3_shaper`  in  1 each  asynchronous PGOOD inputs.
- `on_1v8a_adc`, `on_1v8d_adc`, `on_1v2d_adc`, `on_3v3_tdc`, `on_2v5_tdc`, `on_3v3_shaper`, `on_5v0_sum`, `on_12v5`, `on_n5v0`, `on_5v0_bias`  out  1 each  rail enables, registered.
- `busy`  out  1  a step is ramping up or down.
- `pwr_ready`  out  1  the on-vector equals the desired vector and `busy` is low.
- `fault`  out  1  FAULT is latched.
- `fault_step`  out  3  index of the step that caused the fault.
- `fault_kind`  out  1  0 = ramp timeout, 1 = PGOOD lost at runtime.

## Operation
Steps are ordered as follows; for each: rails, done condition, enabling request.
- 0: `on_1v8a_adc` + `on_1v8d_adc`; done on both PGOODs; enabled by `req[0]`.
- 1: `on_1v2d_adc`; done on `pgood_1v2d_adc`; enabled by `req[0]`.
- 2: `on_3v3_tdc`; done on its PGOOD; enabled by `req[3]`.
- 3: `on_2v5_tdc`; done on settle; enabled by `req[3]`.
- 4: `on_3v3_shaper` + `on_5v0_sum`; done on its PGOOD; enabled by `req[2]`.
- 5: `on_12v5` + `on_n5v0`; done on settle; enabled by `req[4]`.
- 6: `on_5v0_bias`; done on settle; enabled by `req[5] & req[4]`.

Registers and vectors:
- `desired[6:0]` is derived from the request bits above.
- `on_q[6:0]` is the registered step state; the outputs decode from it.
- All PGOODs pass through 2-flop synchronizers. Every PGOOD latency stated in this document includes those 2 cycles.

State machine states: IDLE, RAMP_UP, RAMP_DOWN, FAULT.
- **IDLE:**
  - Down has priority. If any `on_q & ~desired` bit is set, clear the highest such bit, clear the timer, and go to RAMP_DOWN.
  - Otherwise, if any `desired & ~on_q` bit is set, set the lowest such bit, clear the timer, and go to RAMP_UP.
  - Otherwise stay in IDLE.
- **RAMP_UP:**
  - The timer increments every cycle.
  - A PGOOD step is done when its synced PGOOD(s) are high. On done, go to IDLE.
  - If the timer reaches `PG_TIMEOUT-1` before done, go to FAULT with `fault_kind=0`.
  - A settle step is done when the timer reaches `SETTLE_CYCLES-1`.
- **RAMP_DOWN:** go to IDLE when the timer reaches `OFF_DELAY-1`. PGOOD is not checked.
- **FAULT entry:**
  - `on_q` is cleared in a single cycle; there is no ordered shutdown.
  - `fault`, `fault_step` and `fault_kind` latch.
- **FAULT exit:**
  - `fault_clr` moves the FSM to IDLE and clears the fault outputs.
  - Sequencing then restarts from all-off toward the current request.
  - `fault_clr` in any other state is ignored.

Boundary rules:
- Request changes during RAMP_UP or RAMP_DOWN are not acted on until the FSM is back in IDLE.
- Counter width is `$clog2(max(PG_TIMEOUT,SETTLE_CYCLES,OFF_DELAY)+1)`. The counter saturates and never wraps.
- Reset mid-sequence: all outputs go low on the next edge, with no ordered shutdown.

## Timing
- Reset values: all `on_*`, `busy`, `pwr_ready`, `fault`, `fault_step`, `fault_kind` are 0. The state is IDLE. The synchronizers are cleared.
- A request is detected in IDLE on cycle N. The rail output and `busy` are high on cycle N+1.
- A PGOOD pin that rises before edge M is seen as synced on cycle M+1. The FSM returns to IDLE on the following edge, and the next step's rail rises 1 cycle after that.
- A settle step holds RAMP_UP for exactly `SETTLE_CYCLES` cycles. RAMP_DOWN lasts exactly `OFF_DELAY` cycles.
- Timeout: FAULT is entered `PG_TIMEOUT` cycles after the step's rail rose. The rails are low on the next cycle.

## Configuration
- Macro: `PWR_SEQ_PG_MONITOR_EN`.
- **Defined:**
  - In IDLE, RAMP_UP and RAMP_DOWN, a synced PGOOD that reads low for any completed PGOOD step with its `on_q` bit set goes to FAULT with `fault_kind=1`.
  - The step currently ramping up is excluded.
  - If several steps drop at once, `fault_step` reports the lowest index.
  - A monitor fault takes priority over any same-cycle step completion.
- **Undefined:** only ramp timeouts raise a fault, and `fault_kind` is tied to 0.

## Structure
- Package `pwr_seq_pkg` holds:
  - the FSM state enum;
  - step index constants (`STEP_ADC_A` … `STEP_BIAS`);
  - the `N_STEPS=7` constant;
  - the fault-kind enum;
  - the step→request-bit map;
  - the step→has-PGOOD constant vector.
- Sub-module `pwr_pg_sync`: a parameterised-width 2-flop synchronizer with synchronous reset, instantiated once for the 5 PGOOD inputs.

## Test plan
Bench parameters: `PG_TIMEOUT=16`, `SETTLE_CYCLES=4`, `OFF_DELAY=4`.
- **Full power-up:** `reg_pwr_en=6'b111101` with each PGOOD responding 3 cycles after its rail → steps 0 through 6 switch on in order, one at a time; `pwr_ready` rises after step 6 settles; `fault` stays 0.
- **Ordered power-down:** with all on, set `reg_pwr_en=0` → rails drop in the order bias, strip, shaper, 2V5_TDC, 3V3_TDC, 1V2D, ADC 1V8, each drop spaced 5 cycles apart (4-cycle `OFF_DELAY` + 1 IDLE cycle); all outputs end at 0.
- **Timeout:** hold `pgood_1v2d_adc` low → FAULT is entered 16 cycles after `on_1v2d_adc` rises; all rails are 0 on the next cycle; `fault_step=1`, `fault_kind=0`; after `fault_clr`, the ADC step restarts.
- **Runtime loss:** with the `PWR_SEQ_PG_MONITOR_EN` macro defined and all on, drop `pgood_3v3_shaper` → `fault_step=4`, `fault_kind=1`, all rails off. With the macro undefined, there is no fault.
- **HV interlock:** `reg_pwr_en=6'b100000` → no rail asserts and `pwr_ready=1`.
- **Reset mid-ramp:** assert `rst` during step 2 → all outputs are 0 on the next edge.
